// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: queues per-cycle commit events for a trace consumer
// and keeps run statistics (cycles, instructions, I/D cache requests/hits).
// Ports:
//   clk, rst (sync, active-high)
//   commit taps: reg_write, write_reg, write_data, mem_read, mem_write,
//     mem_addr, mem_data_in, mem_data_out, halt
//   cache strobes: icache_req, icache_hit, dcache_req, dcache_hit
//   drain: out_valid, out_ready, out_entry
//   status: overflow, drop_count, done
//   statistics: cycle_count, inst_count, ic_req_count, ic_hit_count,
//     dc_req_count, dc_hit_count
module commit_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_write,
  input  logic [2:0]       write_reg,
  input  logic [15:0]      write_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      mem_data_in,
  input  logic [15:0]      mem_data_out,
  input  logic             halt,
  input  logic             icache_req,
  input  logic             icache_hit,
  input  logic             dcache_req,
  input  logic             dcache_hit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [54:0]      out_entry,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] ic_req_count,
  output logic [CNT_W-1:0] ic_hit_count,
  output logic [CNT_W-1:0] dc_req_count,
  output logic [CNT_W-1:0] dc_hit_count,
  output logic             done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] P1 = 1;
  localparam logic [CNT_W-1:0] C1 = 1;

  typedef enum logic [1:0] {RUN, HALTED, FIN} state_t;

  state_t state, state_nx;

  logic [54:0] mem [DEPTH];
  logic [AW:0] wp, rp, rp_nx;
  logic [54:0] entry;
  logic        empty, full, run, evt;
  logic        push, pop, wr, drop;

  // Wrap bit differs with equal index bits: every slot holds data.
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

  assign run  = (state == RUN);
  assign evt  = reg_write | mem_read | mem_write | halt;
  assign push = run & evt;
  assign pop  = ~empty & out_ready;
  // A full FIFO still takes the entry if the head leaves this cycle.
  assign wr   = push & (~full | pop);
  assign drop = push & full & ~pop;

  assign rp_nx = pop ? rp + P1 : rp;

  assign entry = {
    halt, mem_write, mem_read, mem_addr,
    mem_write ? mem_data_in : mem_data_out,
    reg_write, write_reg, write_data
  };

  assign out_valid = ~empty;
  assign out_entry = empty ? '0 : mem[rp[AW-1:0]];
  assign done      = (state == FIN);

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:     if (halt) state_nx = HALTED;
      // No pushes once halted, so emptiness after this pop is final.
      HALTED:  if (rp_nx == wp) state_nx = FIN;
      FIN:     state_nx = FIN;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp[AW-1:0]] <= entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      wp           <= '0;
      rp           <= '0;
      overflow     <= 1'b0;
      drop_count   <= '0;
      cycle_count  <= '0;
      inst_count   <= '0;
      ic_req_count <= '0;
      ic_hit_count <= '0;
      dc_req_count <= '0;
      dc_hit_count <= '0;
    end else begin
      state <= state_nx;
      rp    <= rp_nx;
      if (wr) wp <= wp + P1;
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= drop_count + C1;
      end
      if (run) begin
        cycle_count <= cycle_count + C1;
        if (halt | reg_write | mem_write)
          inst_count <= inst_count + C1;
        if (icache_req) ic_req_count <= ic_req_count + C1;
        if (icache_hit) ic_hit_count <= ic_hit_count + C1;
        if (dcache_req) dc_req_count <= dc_req_count + C1;
        if (dcache_hit) dc_hit_count <= dc_hit_count + C1;
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: directed vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_commit_trace_buffer;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  logic clk = 0;
  logic rst;
  logic reg_write, mem_read, mem_write, halt;
  logic [2:0] write_reg;
  logic [15:0] write_data, mem_addr, mem_data_in, mem_data_out;
  logic icache_req, icache_hit, dcache_req, dcache_hit;
  logic out_valid, out_ready, overflow, done;
  logic [54:0] out_entry;
  logic [CNT_W-1:0] drop_count, cycle_count, inst_count;
  logic [CNT_W-1:0] ic_req_count, ic_hit_count;
  logic [CNT_W-1:0] dc_req_count, dc_hit_count;

  commit_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .halt(halt), .icache_req(icache_req),
    .icache_hit(icache_hit), .dcache_req(dcache_req),
    .dcache_hit(dcache_hit), .out_valid(out_valid),
    .out_ready(out_ready), .out_entry(out_entry),
    .overflow(overflow), .drop_count(drop_count),
    .cycle_count(cycle_count), .inst_count(inst_count),
    .ic_req_count(ic_req_count), .ic_hit_count(ic_hit_count),
    .dc_req_count(dc_req_count), .dc_hit_count(dc_hit_count),
    .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [54:0] mq[$];
  bit m_halted, m_done, m_ovf;
  longint m_drop, m_cyc, m_inst, m_icr, m_ich, m_dcr, m_dch;

  function automatic logic [54:0] mk(
    logic h, logic mw, logic mr, logic [15:0] a,
    logic [15:0] d, logic rw, logic [2:0] r, logic [15:0] wd);
    return {h, mw, mr, a, d, rw, r, wd};
  endfunction

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic longint wrap(longint v);
    return v & 64'hFFFF_FFFF;
  endfunction

  task automatic model_update();
    bit p, ps, rn, was_halted;
    if (rst) begin
      mq.delete();
      m_halted = 0; m_done = 0; m_ovf = 0;
      m_drop = 0; m_cyc = 0; m_inst = 0;
      m_icr = 0; m_ich = 0; m_dcr = 0; m_dch = 0;
      return;
    end
    was_halted = m_halted;
    rn = !m_halted;
    p  = (mq.size() > 0) && out_ready;
    ps = rn && (reg_write || mem_read || mem_write || halt);
    if (p) void'(mq.pop_front());
    if (ps) begin
      if (mq.size() < DEPTH)
        mq.push_back(mk(halt, mem_write, mem_read, mem_addr,
          mem_write ? mem_data_in : mem_data_out,
          reg_write, write_reg, write_data));
      else begin
        m_ovf = 1;
        m_drop = wrap(m_drop + 1);
      end
    end
    if (rn) begin
      m_cyc = wrap(m_cyc + 1);
      if (halt || reg_write || mem_write) m_inst = wrap(m_inst + 1);
      if (icache_req) m_icr = wrap(m_icr + 1);
      if (icache_hit) m_ich = wrap(m_ich + 1);
      if (dcache_req) m_dcr = wrap(m_dcr + 1);
      if (dcache_hit) m_dch = wrap(m_dch + 1);
    end
    if (was_halted && mq.size() == 0) m_done = 1;
    if (rn && halt) m_halted = 1;
  endtask

  task automatic check_model();
    check("m_valid", out_valid, mq.size() > 0);
    check("m_entry", out_entry, mq.size() > 0 ? mq[0] : 55'd0);
    check("m_ovf", overflow, m_ovf);
    check("m_drop", drop_count, m_drop);
    check("m_cyc", cycle_count, m_cyc);
    check("m_inst", inst_count, m_inst);
    check("m_icr", ic_req_count, m_icr);
    check("m_ich", ic_hit_count, m_ich);
    check("m_dcr", dc_req_count, m_dcr);
    check("m_dch", dc_hit_count, m_dch);
    check("m_done", done, m_done);
  endtask

  task automatic idle();
    reg_write = 0; write_reg = 0; write_data = 0;
    mem_read = 0; mem_write = 0; mem_addr = 0;
    mem_data_in = 0; mem_data_out = 0; halt = 0;
    icache_req = 0; icache_hit = 0;
    dcache_req = 0; dcache_hit = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    idle(); out_ready = 0; rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  typedef struct {
    logic rw; logic [2:0] wr; logic [15:0] wd;
    logic mr; logic mw; logic [15:0] a, di, dout;
    logic rdy;
    logic ev; logic [54:0] ee; logic [31:0] ei;
  } vec_t;

  vec_t tv[5];

  initial begin
    int pops;
    bit seen;

    tv[0] = '{1, 3, 16'h1234, 0, 0, 0, 0, 0, 1,
              1, mk(0, 0, 0, 0, 0, 1, 3, 16'h1234), 1};
    tv[1] = '{0, 0, 0, 0, 1, 16'h0040, 16'h00AA, 0, 0,
              1, mk(0, 0, 0, 0, 0, 1, 3, 16'h1234), 2};
    tv[2] = '{0, 0, 0, 1, 0, 16'h0040, 0, 16'h00AA, 1,
              1, mk(0, 1, 0, 16'h0040, 16'h00AA, 0, 0, 0), 2};
    tv[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,
              1, mk(0, 0, 1, 16'h0040, 16'h00AA, 0, 0, 0), 2};
    tv[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,
              0, 55'd0, 2};

    // reset state
    do_reset();
    check("rst_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_cyc", cycle_count, 0);
    check("rst_inst", inst_count, 0);
    check("rst_drop", drop_count, 0);

    // directed table: reg write, store, load, drain
    for (int i = 0; i < 5; i++) begin
      idle();
      reg_write = tv[i].rw; write_reg = tv[i].wr;
      write_data = tv[i].wd; mem_read = tv[i].mr;
      mem_write = tv[i].mw; mem_addr = tv[i].a;
      mem_data_in = tv[i].di; mem_data_out = tv[i].dout;
      out_ready = tv[i].rdy;
      tick();
      check("tv_valid", out_valid, tv[i].ev);
      check("tv_entry", out_entry, tv[i].ee);
      check("tv_inst", inst_count, tv[i].ei);
    end

    // overflow: 10 events into 8 slots, then push+pop while full
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 10; i++) begin
      idle(); reg_write = 1; write_data = 16'(i);
      tick();
    end
    check("ovf_flag", overflow, 1);
    check("ovf_drop", drop_count, 2);
    idle(); reg_write = 1; write_data = 16'h0BEE; out_ready = 1;
    tick();
    check("full_pp_drop", drop_count, 2);
    check("full_pp_head", out_entry,
          mk(0, 0, 0, 0, 0, 1, 0, 16'd1));

    // halt with 3 queued entries; later events ignored
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      idle(); reg_write = 1; write_reg = 3'(i + 1);
      write_data = 16'(16'h100 + i);
      tick();
    end
    idle(); halt = 1;
    tick();
    check("halt_cyc", cycle_count, 4);
    check("halt_inst", inst_count, 4);
    pops = 0; seen = 0;
    out_ready = 1;
    for (int i = 0; i < 20 && !seen; i++) begin
      idle(); reg_write = 1; mem_write = 1; icache_req = 1;
      halt = 1;
      if (out_valid) pops++;
      tick();
      if (pops < 4) check("halt_notdone", done, 0);
      else begin
        seen = 1;
        check("halt_done", done, 1);
        check("halt_frz_cyc", cycle_count, 4);
        check("halt_frz_inst", inst_count, 4);
        check("halt_frz_icr", ic_req_count, 0);
      end
    end
    if (!seen) check("halt_timeout", 0, 1);
    idle(); tick();
    check("done_held", done, 1);

    // cache counters then mid-run reset
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      idle(); icache_req = 1; icache_hit = (i < 3);
      dcache_req = (i < 2); dcache_hit = (i < 2);
      reg_write = 1;
      tick();
    end
    check("c_icr", ic_req_count, 5);
    check("c_ich", ic_hit_count, 3);
    check("c_dcr", dc_req_count, 2);
    check("c_dch", dc_hit_count, 2);
    idle(); rst = 1; tick(); rst = 0;
    check("c_rst_icr", ic_req_count, 0);
    check("c_rst_dch", dc_hit_count, 0);
    check("c_rst_valid", out_valid, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int k;
      idle();
      rst = ($urandom_range(0, 149) == 0) ||
            (m_done && $urandom_range(0, 3) == 0);
      k = $urandom_range(0, 3);
      reg_write = $urandom_range(0, 1);
      write_reg = 3'($urandom);
      write_data = 16'($urandom);
      mem_read = (k == 1);
      mem_write = (k == 2);
      mem_addr = 16'($urandom);
      mem_data_in = 16'($urandom);
      mem_data_out = 16'($urandom);
      halt = ($urandom_range(0, 59) == 0);
      icache_req = $urandom_range(0, 1);
      icache_hit = $urandom_range(0, 1);
      dcache_req = $urandom_range(0, 1);
      dcache_hit = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 9) < 4);
      tick();
    end
    rst = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
